dm_stream_loader: RTL and testbench
===================================

Name: dm_stream_loader

Overview:
- Host-side front end of the shared data memory. Drives the memory's loader port (write enable, address, write data, read data).
- Accepts a 16-bit word stream: matrix dimensions, then matrix A, then matrix B. Writes these into data memory at fixed layout addresses.
- Then pulses the cores to start, waits for their completion flag, and streams result matrix C back out with valid/ready backpressure.

Parameters:
- MAX_DIM, 16, largest legal value of m, n or p.
- DIM_BASE, 0, memory address of the header word m; n and p follow at +1 and +2.
- DATA_W, 16, stream and memory word width.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts the input word.
- in_data  in  DATA_W  header or matrix element.
- dm_write_en  out  1  memory loader-port write enable.
- dm_addr  out  ADDR_W  memory loader-port address.
- dm_input_data  out  DATA_W  memory loader-port write data.
- dm_output_data  in  DATA_W  memory loader-port read data, registered, valid 1 cycle after address with dm_write_en=0.
- start_cores  out  1  single-cycle start pulse to all four cores.
- cores_done  in  1  level, all cores finished.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result word.
- out_data  out  DATA_W  result element of C, row-major.
- busy  out  1  high in every state except IDLE.
- err  out  1  illegal header detected; cleared when the next word is accepted in HDR.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Memory contents are not touched by reset.
- Memory layout:
  - A_BASE = DIM_BASE+3.
  - B_BASE = A_BASE+m*n.
  - C_BASE = B_BASE+n*p.
  - All arithmetic is unsigned at ADDR_W bits; with the defaults the worst case is 3+768 words, which fits the 2048-word memory.
- Input handshake: a word transfers when in_valid && in_ready. in_ready=1 only in HDR and LOAD. in_valid is ignored in all other states.
- Write timing: dm_write_en, dm_addr and dm_input_data are registered. A transfer in cycle t produces a memory write in cycle t+1. dm_write_en=0 in every cycle with no transfer.
- FSM:
  - IDLE: next cycle -> HDR.
  - HDR: accepts 3 words m, n, p. Each is written to DIM_BASE+0..2 and latched. After the 3rd word:
    - if any of m, n, p is 0 or > MAX_DIM: set err, -> IDLE (words already written remain in memory);
    - else -> LOAD with the load counter at 0.
  - LOAD: accepts m*n+n*p words. Word k is written to A_BASE+k. B follows contiguously, so no separate B state is needed. After the last word -> START.
  - START: start_cores=1 for exactly one cycle, -> WAIT_DONE. This state is entered one cycle after the last transfer, so the final write is already committed before start_cores rises.
  - WAIT_DONE: cores_done is sampled only in this state. cores_done=1 -> RD_ADDR with the read counter at 0. A cores_done already high on entry is accepted on the first WAIT_DONE cycle.
  - RD_ADDR: dm_addr=C_BASE+r, dm_write_en=0, -> RD_DATA.
  - RD_DATA: the memory returns data. Capture dm_output_data into out_data, set out_valid=1, -> RD_OUT.
  - RD_OUT: hold out_valid and out_data stable until out_ready. On the handshake: out_valid=0, then
    - if r = m*p-1 -> IDLE;
    - else increment r -> RD_ADDR.
- Throughput: readback is 3 cycles per word minimum; loading is 1 word per cycle.
- Counters and products: 16-bit. m*n, n*p and m*p are computed once at header completion and registered.
- Reset mid-operation: returns immediately to IDLE with all outputs 0. Any memory write already issued stands; a pending start_cores pulse is suppressed.
- The cores share the memory write path, so this block only drives the loader port and never arbitrates.

Decomposition:
- Shared package dm_pkg holds:
  - the state enum (IDLE, HDR, LOAD, START, WAIT_DONE, RD_ADDR, RD_DATA, RD_OUT);
  - DIM_BASE;
  - the header offsets (0, 1, 2) and A_BASE offset 3, which the core programs also use.
- No sub-module is needed. A small output holding register is kept inline.

Test Plan:
- Legal 2x2x2 load: stream 2,2,2, A=1,2,3,4, B=5,6,7,8 with in_valid held high.
  - Expect writes (0,2),(1,2),(2,2),(3,1)..(6,4),(7,5)..(10,8) on consecutive cycles.
  - Expect start_cores high one cycle after the write to address 10.
- Readback: model memory so that C=19,22,43,50 sits at 11..14, assert cores_done, stall out_ready randomly.
  - Expect out_data 19,22,43,50 in order, each held stable while out_valid && !out_ready, then busy=0.
- Illegal header: stream 0,2,2 -> err=1, FSM back to IDLE, start_cores never asserted. A following legal header clears err on its first accepted word.
- Oversize header: stream 17,1,1 -> err=1. Stream 16,16,16 -> loads 512 words to 3..514, then start_cores.
- Input gaps: in_valid toggling every other cycle during LOAD -> dm_write_en pulses only after transfers, addresses contiguous with no skips.
- Reset mid-LOAD after 3 A words -> all outputs 0 the same cycle, start_cores never asserted. A fresh stream then loads correctly from the header.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory loader and the core programs that
// read the same memory layout.
package dm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    START,
    WAIT_DONE,
    RD_ADDR,
    RD_DATA,
    RD_OUT
  } dm_state_e;

  localparam int DIM_BASE  = 0;
  // Header word offsets from DIM_BASE, then matrix A right after the header
  localparam int HDR_M_OFS = 0;
  localparam int HDR_N_OFS = 1;
  localparam int HDR_P_OFS = 2;
  localparam int A_OFS     = 3;

endpackage

// File: rtl/dm_stream_loader_if.sv
// Host stream, memory loader port, core control and status of the loader.
interface dm_stream_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              dm_write_en;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_input_data;
  logic [DATA_W-1:0] dm_output_data;
  logic              start_cores;
  logic              cores_done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              err;

  modport mst (
    input  in_valid, in_data, dm_output_data, cores_done, out_ready,
    output in_ready, dm_write_en, dm_addr, dm_input_data, start_cores,
           out_valid, out_data, busy, err
  );

  modport slv (
    output in_valid, in_data, dm_output_data, cores_done, out_ready,
    input  in_ready, dm_write_en, dm_addr, dm_input_data, start_cores,
           out_valid, out_data, busy, err
  );
endinterface

// File: rtl/dm_stream_loader.sv
// Streams header + A + B into data memory, kicks the cores, then streams C
// back out one word per 3-cycle read with valid/ready backpressure.
module dm_stream_loader
  import dm_pkg::*;
#(
  parameter int MAX_DIM  = 16,
  parameter int DIM_BASE = dm_pkg::DIM_BASE,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  dm_stream_loader_if.mst bus
);

  dm_state_e         r_state, w_nxt;
  logic [1:0]        r_hdr_cnt;
  logic [15:0]       r_m, r_n;
  logic [15:0]       r_ld_last, r_mp;
  logic [15:0]       r_ld_cnt, r_rd_cnt;
  logic [ADDR_W-1:0] r_c_base;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_start;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_data;
  logic              r_err;

  logic        w_in_rdy, w_xfer, w_hdr_last, w_hdr_bad, w_ld_last, w_out_hs, w_rd_last;
  logic [15:0] w_p, w_mn, w_np, w_mp;

  assign w_in_rdy   = (r_state == HDR) || (r_state == LOAD);
  assign w_xfer     = bus.in_valid && w_in_rdy;
  assign w_p        = 16'(bus.in_data);
  assign w_mn       = r_m * r_n;
  assign w_np       = r_n * w_p;
  assign w_mp       = r_m * w_p;
  assign w_hdr_last = (r_state == HDR) && w_xfer && (r_hdr_cnt == 2'd2);
  assign w_hdr_bad  = (r_m == 16'd0) || (r_m > 16'(MAX_DIM)) ||
                      (r_n == 16'd0) || (r_n > 16'(MAX_DIM)) ||
                      (w_p == 16'd0) || (w_p > 16'(MAX_DIM));
  assign w_ld_last  = (r_state == LOAD) && w_xfer && (r_ld_cnt == r_ld_last);
  assign w_out_hs   = (r_state == RD_OUT) && bus.out_ready;
  assign w_rd_last  = (r_rd_cnt == r_mp - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:      w_nxt = HDR;
      HDR:       if (w_hdr_last) w_nxt = w_hdr_bad ? IDLE : LOAD;
      LOAD:      if (w_ld_last) w_nxt = START;
      START:     w_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.cores_done) w_nxt = RD_ADDR;
      RD_ADDR:   w_nxt = RD_DATA;
      RD_DATA:   w_nxt = RD_OUT;
      RD_OUT:    if (bus.out_ready) w_nxt = w_rd_last ? IDLE : RD_ADDR;
      default:   w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_cnt  <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_ld_last  <= '0;
      r_mp       <= '0;
      r_ld_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_c_base   <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_start    <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      // Registered so the pulse lands after the last load write has committed
      r_start <= (r_state == START);

      if (w_xfer) begin
        r_we    <= 1'b1;
        r_wdata <= bus.in_data;
        r_addr  <= (r_state == HDR) ? ADDR_W'(DIM_BASE) + ADDR_W'(r_hdr_cnt)
                                    : ADDR_W'(DIM_BASE + A_OFS) + ADDR_W'(r_ld_cnt);
      end

      if ((r_state == HDR) && w_xfer) begin
        r_err     <= 1'b0;
        r_hdr_cnt <= r_hdr_cnt + 2'd1;
        if (r_hdr_cnt == 2'd0) r_m <= w_p;
        if (r_hdr_cnt == 2'd1) r_n <= w_p;
        if (w_hdr_last) begin
          r_hdr_cnt <= '0;
          r_err     <= w_hdr_bad;
          r_ld_cnt  <= '0;
          r_ld_last <= w_mn + w_np - 16'd1;
          r_mp      <= w_mp;
          r_c_base  <= ADDR_W'(DIM_BASE + A_OFS) + ADDR_W'(w_mn) + ADDR_W'(w_np);
        end
      end

      if ((r_state == LOAD) && w_xfer) r_ld_cnt <= r_ld_cnt + 16'd1;

      if ((r_state == WAIT_DONE) && bus.cores_done) begin
        r_rd_cnt <= '0;
        r_addr   <= r_c_base;
      end

      if (r_state == RD_DATA) begin
        r_out_data <= bus.dm_output_data;
        r_out_vld  <= 1'b1;
      end

      if (w_out_hs) begin
        r_out_vld <= 1'b0;
        if (!w_rd_last) begin
          r_rd_cnt <= r_rd_cnt + 16'd1;
          r_addr   <= r_c_base + ADDR_W'(r_rd_cnt + 16'd1);
        end
      end
    end
  end

  assign bus.in_ready      = w_in_rdy;
  assign bus.dm_write_en   = r_we;
  assign bus.dm_addr       = r_addr;
  assign bus.dm_input_data = r_wdata;
  assign bus.start_cores   = r_start;
  assign bus.out_valid     = r_out_vld;
  assign bus.out_data      = r_out_data;
  assign bus.busy          = (r_state != IDLE);
  assign bus.err           = r_err;

endmodule

// File: tb/tb_dm_stream_loader.sv
// Directed bench for dm_stream_loader with a 2048-word registered-read memory model.
module tb_dm_stream_loader;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          c;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_stream_loader_if #(.DATA_W(16), .ADDR_W(16)) bus();

  dm_stream_loader #(.MAX_DIM(16), .DIM_BASE(0), .DATA_W(16), .ADDR_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.mst)
  );

  logic [15:0] mem [0:2047];
  logic        pre_en = 1'b0;
  logic [10:0] pre_a  = '0;
  logic [15:0] pre_d  = '0;
  int          cyc = 0;
  wr_t         wq[$];
  int          xq[$];
  int          sq[$];
  int          n_chk = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    if (bus.dm_write_en) begin
      mem[bus.dm_addr[10:0]] <= bus.dm_input_data;
      wq.push_back('{a: bus.dm_addr, d: bus.dm_input_data, c: cyc});
    end else begin
      bus.dm_output_data <= mem[bus.dm_addr[10:0]];
    end
    if (bus.start_cores) sq.push_back(cyc);
    if (bus.in_valid && bus.in_ready) xq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", bus.in_ready, 1);
    else @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.cores_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [15:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t1w [11] = '{16'd2, 16'd2, 16'd2, 16'd1, 16'd2, 16'd3, 16'd4,
                              16'd5, 16'd6, 16'd7, 16'd8};
    logic [15:0] cexp [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
    int w0, s0, x0, got, t, bad;
    logic rdy, prev_stall;
    logic [15:0] prev_d;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.cores_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_we", bus.dm_write_en, 0);
    chk("rst_addr", bus.dm_addr, 0);
    chk("rst_wdata", bus.dm_input_data, 0);
    chk("rst_start", bus.start_cores, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;

    // Legal 2x2x2 load, in_valid held high
    w0 = wq.size(); s0 = sq.size();
    for (int i = 0; i < 11; i++) send(t1w[i]);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_nwr", wq.size() - w0, 11);
    chk("t1_nstart", sq.size() - s0, 1);
    if (wq.size() - w0 >= 11) begin
      for (int i = 0; i < 11; i++) begin
        chk("t1_addr", wq[w0+i].a, i);
        chk("t1_data", wq[w0+i].d, t1w[i]);
        chk("t1_cyc", wq[w0+i].c - wq[w0].c, i);
      end
      if (sq.size() > s0) chk("t1_start_cyc", sq[s0], wq[w0+10].c + 1);
    end
    chk("t1_busy", bus.busy, 1);

    // Readback with random out_ready stalls
    for (int i = 0; i < 4; i++) preload(11'(11 + i), cexp[i]);
    bus.cores_done = 1'b1;
    got = 0; t = 0; prev_stall = 1'b0; prev_d = '0;
    while (got < 4 && t < 300) begin
      rdy = ($urandom_range(0, 2) != 0);
      bus.out_ready = rdy;
      if (bus.out_valid) begin
        if (prev_stall) chk("rd_hold", bus.out_data, prev_d);
        if (rdy) begin
          chk("rd_data", bus.out_data, cexp[got]);
          got++;
        end
        prev_stall = !rdy;
        prev_d     = bus.out_data;
      end else begin
        if (prev_stall) chk("rd_vld_hold", bus.out_valid, 1);
        prev_stall = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    chk("rd_count", got, 4);
    chk("rd_busy", bus.busy, 0);
    chk("rd_vld_off", bus.out_valid, 0);
    bus.out_ready = 1'b0; bus.cores_done = 1'b0;

    // Illegal header, then err clears on the next accepted header word
    do_reset();
    s0 = sq.size();
    send(16'd0); send(16'd2); send(16'd2);
    bus.in_valid = 1'b0;
    chk("ill_err", bus.err, 1);
    chk("ill_busy", bus.busy, 0);
    repeat (4) @(negedge clk);
    chk("ill_nostart", sq.size() - s0, 0);
    send(16'd3);
    bus.in_valid = 1'b0;
    chk("ill_err_clr", bus.err, 0);

    // Oversize header
    do_reset();
    send(16'd17); send(16'd1); send(16'd1);
    bus.in_valid = 1'b0;
    chk("ovr_err", bus.err, 1);
    chk("ovr_busy", bus.busy, 0);

    // Maximum 16x16x16 load: 512 words to 3..514
    do_reset();
    w0 = wq.size(); s0 = sq.size();
    send(16'd16); send(16'd16); send(16'd16);
    for (int k = 0; k < 512; k++) send(16'(k * 3 + 1));
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("big_err", bus.err, 0);
    chk("big_nwr", wq.size() - w0, 515);
    chk("big_nstart", sq.size() - s0, 1);
    if (wq.size() - w0 >= 515) begin
      bad = 0;
      for (int i = 3; i < 515; i++)
        if (wq[w0+i].a != 16'(i) || wq[w0+i].d != 16'((i - 3) * 3 + 1)) bad++;
      chk("big_contig", bad, 0);
      if (sq.size() > s0) chk("big_start_cyc", sq[s0], wq[w0+514].c + 1);
    end

    // Gapped input during LOAD: 2x1x2 -> 4 words at 3..6
    do_reset();
    w0 = wq.size(); x0 = xq.size();
    send(16'd2); send(16'd1); send(16'd2);
    for (int k = 0; k < 4; k++) begin
      send(16'(10 + k));
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("gap_nwr", wq.size() - w0, 7);
    chk("gap_nxfer", xq.size() - x0, 7);
    if (wq.size() - w0 >= 7 && xq.size() - x0 >= 7) begin
      for (int i = 0; i < 7; i++) begin
        chk("gap_addr", wq[w0+i].a, i);
        chk("gap_after_xfer", wq[w0+i].c, xq[x0+i] + 1);
      end
      for (int i = 3; i < 7; i++) begin
        chk("gap_data", wq[w0+i].d, 10 + i - 3);
        if (i > 3) chk("gap_spacing", wq[w0+i].c - wq[w0+i-1].c, 2);
      end
    end

    // Reset in the middle of LOAD after 3 A words
    do_reset();
    s0 = sq.size();
    send(16'd2); send(16'd2); send(16'd2);
    send(16'd1); send(16'd2); send(16'd3);
    bus.in_data = 16'd4;
    rst_n = 1'b0;
    #1;
    chk("mid_we", bus.dm_write_en, 0);
    chk("mid_addr", bus.dm_addr, 0);
    chk("mid_wdata", bus.dm_input_data, 0);
    chk("mid_in_ready", bus.in_ready, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_start", bus.start_cores, 0);
    chk("mid_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_nostart", sq.size() - s0, 0);
    rst_n = 1'b1;
    w0 = wq.size();
    send(16'd1); send(16'd1); send(16'd1); send(16'd7); send(16'd9);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("re_nwr", wq.size() - w0, 5);
    if (wq.size() - w0 >= 5) begin
      for (int i = 0; i < 5; i++) chk("re_addr", wq[w0+i].a, i);
      chk("re_a_data", wq[w0+3].d, 7);
      chk("re_b_data", wq[w0+4].d, 9);
    end
    chk("re_nstart", sq.size() - s0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
